// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit that sits beside the execute-stage ALU and
//   implements MULT, MULTU, DIV and DIVU. Results go to the architectural
//   HI/LO registers. An operation takes WIDTH+1 cycles from the start edge to
//   the one-cycle done pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; aborts any operation, clears HI/LO
//   start        request, sampled only while idle
//   op[1:0]      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b         rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   hi_we/hi_in  MTHI write, honoured only while idle
//   lo_we/lo_in  MTLO write, honoured only while idle
//   busy         operation in flight (pipeline stalls on this)
//   done         one-cycle pulse; HI/LO hold the new result in this cycle
//   hi, lo       HI / LO registers (MFHI / MFLO sources)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;   // mult: product; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // mult: |multiplicand|; div: |divisor|
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;     // product / quotient must be negated
  logic               rneg_q, rneg_d;   // remainder must be negated (dividend sign)
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand magnitudes; only the signed ops (op[0]=1) look at the sign bits.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One radix-2 shift-add step: add the multiplicand into the upper half when
  // the current multiplier bit (LSB) is set, then shift the whole pair right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  // One restoring-division step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits and shift the quotient bit in.
  // The difference always fits in WIDTH bits when the subtraction is taken,
  // so only the low WIDTH bits are formed.
  logic [WIDTH:0]     div_tmp;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_tmp  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_ge   = div_tmp >= {1'b0, opnd_q};
  assign div_rem  = div_tmp[WIDTH-1:0] - opnd_q;
  assign div_next = {(div_ge ? div_rem : div_tmp[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign prod_fix = neg_q  ? -work_q : work_q;
  assign quot_fix = neg_q  ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // MTHI/MTLO land now; a start in the same cycle overwrites them at FIX.
        if (hi_we) hi_d = hi_in;
        if (lo_we) lo_d = lo_in;
        if (start) begin
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          div0_d   = (b == {WIDTH{1'b0}});
          opnd_d   = op[1] ? b_mag : a_mag;
          work_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        work_d = is_div_q ? div_next : mul_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          // Divide by zero returns all ones; the remainder path already
          // reproduces the dividend, sign included.
          lo_d = div0_q ? {WIDTH{1'b1}} : quot_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments for all state so every register
      // samples the pre-edge values, independent of statement order.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed bench for muldiv_unit. A behavioural model (plain arithmetic plus
//   a countdown to the done cycle) predicts busy/done/hi/lo, and a compare
//   process checks them every cycle after reset. Directed sequences also check
//   hand-computed HI/LO values, latency, done-pulse counts and reset abort.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         hi_we, lo_we;
  logic [W-1:0] hi_in, lo_in;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_pass   = 0;
  int n_total  = 0;
  int done_cnt = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi_in (hi_in),
    .lo_in (lo_in),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Architectural result {HI, LO} of one operation.
  function automatic logic [63:0] model_res(input logic [1:0] fo, input logic [31:0] fa,
                                            input logic [31:0] fb);
    longint sa, sb, q, r;
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    case (fo)
      2'b00: return {32'h0, fa} * {32'h0, fb};
      2'b01: return 64'(sa * sb);
      2'b10: begin
        if (fb == 0) return {fa, 32'hFFFF_FFFF};
        return {fa % fb, fa / fb};
      end
      default: begin
        if (fb == 0) return {fa, 32'hFFFF_FFFF};
        if (fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Cycle-level expectation: idle accepts writes/start; a started op reports
  // its result WIDTH+1 edges later.
  bit          m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (hi_we) m_hi <= hi_in;
      if (lo_we) m_lo <= lo_in;
      if (start) begin
        m_pend <= model_res(op, a, b);
        m_busy <= 1'b1;
        m_left <= W + 1;
      end
    end else if (m_left == 1) begin
      m_hi   <= m_pend[63:32];
      m_lo   <= m_pend[31:0];
      m_busy <= 1'b0;
      m_done <= 1'b1;
      m_left <= 0;
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("hi",   64'(hi),   64'(m_hi));
      check("lo",   64'(lo),   64'(m_lo));
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until done is seen; returns cycles counted since start edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  // Issues one op in the current cycle and waits for its done pulse. Operand
  // inputs are scrambled during the run; they must have no effect.
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    int lat;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; op = ~o; a = ~x; b = y ^ 32'h5A5A_5A5A;
    wait_done(lat);
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " HI"}, 64'(hi), 64'(exp_hi));
    check({name, " LO"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int lat, d0;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; hi_in = '0; lo_in = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi",   64'(hi),   64'd0);
    check("reset lo",   64'(lo),   64'd0);
    reset = 1'b0;
    tick();

    // Consecutive calls start on the done cycle: back-to-back with no bubble.
    do_op("MULTU max",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("MULT -3*7",   2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("DIV -7/2",    2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("DIVU 100/7",  2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
    do_op("DIVU by 0",   2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF);
    do_op("DIV ovf",     2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    do_op("DIV neg/0",   2'b11, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    do_op("DIV 100/-7",  2'b11, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
    do_op("MULT min^2",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    tick();

    // MTHI/MTLO together with start: writes land first, result overwrites.
    op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
    hi_we = 1'b1; hi_in = 32'h1111_1111; lo_we = 1'b1; lo_in = 32'h2222_2222;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("start+MTHI hi", 64'(hi), 64'h1111_1111);
    check("start+MTLO lo", 64'(lo), 64'h2222_2222);
    wait_done(lat);
    check("start+MT latency", 64'(lat), 64'd33);
    check("start+MT HI", 64'(hi), 64'h2);
    check("start+MT LO", 64'(lo), 64'hE);
    tick();

    // Second start and MTHI/MTLO in the middle of a MULTU run are ignored.
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1; op = 2'b11; a = 32'hFFFF_0000; b = 32'd9;
    hi_we = 1'b1; hi_in = 32'hDEAD_BEEF; lo_we = 1'b1; lo_in = 32'hBEEF_DEAD;
    d0 = done_cnt;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_done(lat);
    check("busy-ignore latency", 64'(lat), 64'd23);
    check("busy-ignore HI", 64'(hi), 64'h0);
    check("busy-ignore LO", 64'(lo), 64'hF);
    repeat (40) tick();
    check("busy-ignore done pulses", 64'(done_cnt - d0), 64'd1);

    // MTLO while idle takes effect on the next cycle.
    lo_we = 1'b1; lo_in = 32'hCAFE_F00D;
    tick();
    lo_we = 1'b0;
    check("MTLO lo", 64'(lo), 64'hCAFE_F00D);
    check("MTLO hi kept", 64'(hi), 64'h0);

    // Reset at cycle 15 of a DIV aborts it without a done pulse.
    op = 2'b11; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    d0 = done_cnt;
    tick();
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    reset = 1'b0;
    repeat (40) tick();
    check("abort done pulses", 64'(done_cnt - d0), 64'd0);

    do_op("after reset DIVU", 2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
